lsu_data_ram: RTL and testbench

Parametrised, handshaked data memory for the load/store path. It replaces the fixed 32-bit, combinational-read data RAM with the following features:
- configurable width and depth;
- registered one-cycle read;
- byte/half/word (and double, at 64 bits) loads and stores, with alignment and sign/zero extension done in-block;
- misalignment and out-of-range error reporting;
- a single-entry response register with backpressure.

It sits behind the MEM stage. The MEM stage issues one request per accepted handshake and consumes one response per request, in order.

---
 rtl/lsu_data_ram.sv | 91 +++++++++
 tb/tb_lsu_data_ram.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lsu_data_ram.sv
// lsu_data_ram: handshaked load/store data memory with a registered one-cycle read,
// in-block lane alignment and extension, error reporting and a single-entry response register.
module lsu_data_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX   = $clog2(DEPTH);
    localparam int SW    = $clog2(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic [OFF-1:0]    w_off;
    logic [IDX-1:0]    w_idx;
    logic [2:0]        w_align;
    logic              w_err;
    logic              w_acc;
    logic [BYTES-1:0]  w_lane_mask;
    logic [BYTES-1:0]  w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [6:0]        w_nbits;
    logic [SW-1:0]     w_msb_idx;
    logic [DATA_W-1:0] w_keep;
    logic [DATA_W-1:0] w_sh;
    logic              w_sign;
    logic [DATA_W-1:0] w_ld;

    assign w_off   = req_addr[OFF-1:0];
    assign w_idx   = req_addr[IDX+OFF-1:OFF];
    assign w_align = 3'((4'd1 << req_size) - 4'd1);
    assign w_err   = (|req_addr[ADDR_W-1:IDX+OFF]) || (|(req_addr[2:0] & w_align))
                   || (req_size == 2'd3 && DATA_W == 32);

    assign req_ready = !r_valid || resp_ready;
    assign w_acc     = req_valid && req_ready;

    assign w_lane_mask = BYTES'((9'd1 << (4'd1 << req_size)) - 9'd1);
    assign w_be        = w_lane_mask << w_off;
    assign w_wdata     = req_wdata << {w_off, 3'b000};

    // Keep mask covers the access width; a full-width access shifts all ones out, keeping everything.
    assign w_nbits   = 7'd8 << req_size;
    assign w_msb_idx = SW'(w_nbits - 7'd1);
    assign w_keep    = ~({DATA_W{1'b1}} << w_nbits);
    assign w_sh      = r_mem[w_idx] >> {w_off, 3'b000};
    assign w_sign    = !req_unsigned && w_sh[w_msb_idx];
    assign w_ld      = (w_sh & w_keep) | (w_sign ? ~w_keep : '0);

    always_ff @(posedge clk) begin
        if (rst_n && w_acc && req_we && !w_err)
            for (int b = 0; b < BYTES; b++)
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_err   <= w_err;
            r_rdata <= (w_err || req_we) ? '0 : w_ld;
        end else if (resp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign resp_valid = r_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
endmodule

// File: tb/tb_lsu_data_ram.sv
// tb_lsu_data_ram: drives a 32-bit and a 64-bit instance against a byte-array reference model.
module tb_lsu_data_ram;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0, a_req_unsigned = 1'b0;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0, a_resp_rdata;
    logic [1:0]  a_req_size = '0;
    logic        a_resp_valid, a_resp_ready = 1'b1, a_resp_err;

    logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0, b_req_unsigned = 1'b0;
    logic [31:0] b_req_addr = '0;
    logic [63:0] b_req_wdata = '0, b_resp_rdata;
    logic [1:0]  b_req_size = '0;
    logic        b_resp_valid, b_resp_ready = 1'b1, b_resp_err;

    lsu_data_ram #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_size(a_req_size), .req_unsigned(a_req_unsigned),
        .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    lsu_data_ram #(.DATA_W(64), .DEPTH(DEPTH), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
        .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  mem32 [DEPTH*4];
    logic [7:0]  mem64 [DEPTH*8];
    bit          m_vld [2];
    bit          m_er  [2];
    logic [63:0] m_rd  [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Little-endian byte-addressed memory: an access touches bytes addr..addr+size-1.
    function automatic void model(input bit s, input bit we, input logic [31:0] addr,
                                  input logic [1:0] sz, input bit uns, input logic [63:0] wd,
                                  output logic [63:0] rd, output bit err);
        int nb = 1 << sz;
        int bytes = s ? 8 : 4;
        logic [63:0] v = '0;
        rd  = '0;
        err = (addr >= 32'(DEPTH * bytes)) || (addr % nb != 0) || (nb > bytes);
        if (err) return;
        for (int i = 0; i < nb; i++)
            if (we) begin
                if (s) mem64[addr + i] = wd[8*i +: 8];
                else   mem32[addr + i] = wd[8*i +: 8];
            end else
                v[8*i +: 8] = s ? mem64[addr + i] : mem32[addr + i];
        if (!we) begin
            if (!uns && nb < bytes && v[8*nb-1])
                for (int i = 8*nb; i < 8*bytes; i++) v[i] = 1'b1;
            rd = v;
        end
    endfunction

    task automatic cyc(input bit s, input bit v, input bit we, input logic [31:0] addr,
                       input logic [1:0] sz, input bit uns, input logic [63:0] wd, input bit rr);
        bit acc, er;
        logic [63:0] rd;
        int w = s ? 64 : 32;
        @(negedge clk);
        a_req_valid = v && !s;  a_resp_ready = s ? 1'b1 : rr;
        b_req_valid = v && s;   b_resp_ready = s ? rr : 1'b1;
        a_req_we = we; b_req_we = we; a_req_addr = addr; b_req_addr = addr;
        a_req_size = sz; b_req_size = sz; a_req_unsigned = uns; b_req_unsigned = uns;
        a_req_wdata = wd[31:0]; b_req_wdata = wd;
        #1;
        chk($sformatf("rdy%0d", w), 64'(s ? b_req_ready : a_req_ready), 64'(!m_vld[s] || rr));
        acc = v && (!m_vld[s] || rr);
        @(posedge clk);
        #1;
        if (acc) begin
            model(s, we, addr, sz, uns, wd, rd, er);
            m_vld[s] = 1'b1; m_rd[s] = rd; m_er[s] = er;
        end else if (rr) m_vld[s] = 1'b0;
        m_vld[!s] = 1'b0;
        chk($sformatf("vld%0d", w), 64'(s ? b_resp_valid : a_resp_valid), 64'(m_vld[s]));
        if (m_vld[s]) begin
            chk($sformatf("rdata%0d", w), s ? b_resp_rdata : {32'h0, a_resp_rdata}, m_rd[s]);
            chk($sformatf("err%0d", w), 64'(s ? b_resp_err : a_resp_err), 64'(m_er[s]));
        end
    endtask

    initial begin
        logic [31:0] addr;
        logic [1:0]  sz;
        m_vld[0] = 0; m_vld[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld32", 64'(a_resp_valid), 64'd0);
        chk("rst_rd32", {32'h0, a_resp_rdata}, 64'd0);
        chk("rst_vld64", 64'(b_resp_valid), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 1, 32'(i*4), 2, 0, {$urandom, $urandom}, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 1, 32'(i*8), 3, 0, {$urandom, $urandom}, 1);

        cyc(0, 1, 1, 32'h10, 2, 0, 64'hDEADBEEF, 1);
        cyc(0, 1, 0, 32'h10, 2, 0, 0, 1);
        chk("ld_word", {32'h0, a_resp_rdata}, 64'hDEADBEEF);
        cyc(0, 1, 1, 32'h13, 0, 0, 64'h80, 1);
        cyc(0, 1, 0, 32'h13, 0, 0, 0, 1);
        chk("ld_sbyte", {32'h0, a_resp_rdata}, 64'hFFFFFF80);
        cyc(0, 1, 0, 32'h13, 0, 1, 0, 1);
        chk("ld_ubyte", {32'h0, a_resp_rdata}, 64'h80);
        cyc(0, 1, 0, 32'h10, 2, 0, 0, 1);
        chk("ld_merge", {32'h0, a_resp_rdata}, 64'h80ADBEEF);

        cyc(0, 1, 0, 32'h11, 1, 0, 0, 1);
        chk("mis_err", {63'h0, a_resp_err}, 64'd1);
        cyc(0, 1, 1, 32'(DEPTH*4), 2, 0, 64'h12345678, 1);
        chk("oor_err", {63'h0, a_resp_err}, 64'd1);
        cyc(0, 1, 0, 32'h10, 2, 0, 0, 1);
        chk("unchanged", {32'h0, a_resp_rdata}, 64'h80ADBEEF);

        cyc(0, 1, 0, 32'h10, 2, 0, 0, 1);
        repeat (3) begin
            cyc(0, 1, 0, 32'h14, 2, 0, 0, 0);
            chk("stall_rdy", 64'(a_req_ready), 64'd0);
            chk("hold", {32'h0, a_resp_rdata}, 64'h80ADBEEF);
        end
        cyc(0, 1, 0, 32'h14, 2, 0, 0, 1);

        cyc(1, 1, 1, 32'h8, 3, 0, 64'h0123456789ABCDEF, 1);
        cyc(1, 1, 0, 32'hE, 1, 0, 0, 1);
        chk("ld_h64", b_resp_rdata, 64'h0123);
        cyc(0, 1, 0, 32'h8, 3, 0, 0, 1);
        chk("sz3_err32", {63'h0, a_resp_err}, 64'd1);

        cyc(0, 1, 0, 32'h10, 2, 0, 0, 1);
        cyc(0, 1, 0, 32'h10, 2, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10; a_req_size = 2'd2;
        a_req_wdata = 32'h11111111; a_resp_ready = 1'b1;
        #1;
        chk("arst_vld", 64'(a_resp_valid), 64'd0);
        chk("arst_rd", {32'h0, a_resp_rdata}, 64'd0);
        chk("arst_err", 64'(a_resp_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; a_req_valid = 1'b0;
        m_vld[0] = 0; m_vld[1] = 0;
        cyc(0, 1, 0, 32'h10, 2, 0, 0, 1);
        chk("post_rst", {32'h0, a_resp_rdata}, 64'h80ADBEEF);

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 400; i++) begin
                sz = 2'($urandom_range(0, 3));
                addr = ($urandom_range(0, 9) == 0) ? $urandom
                     : 32'($urandom_range(0, DEPTH * (s ? 8 : 4) + 15));
                if ($urandom_range(0, 1) == 1) addr = addr & ~32'((1 << sz) - 1);
                cyc(s[0], $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, addr, sz,
                    $urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
            end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
